mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL provide clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-002 SHALL provide reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL provide stall, input, 1 bit: global pipeline stall, including this block's busy.
REQ-004 SHALL provide flush, input, 1 bit: pipeline flush.
REQ-005 SHALL provide ex_en, input, 1 bit: EX/MEM data valid.
REQ-006 SHALL provide ex_mem_op, input, 4 bits: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NOP.
REQ-007 SHALL provide ex_addr, input, 32 bits: byte address.
REQ-008 SHALL provide ex_wr_data, input, 32 bits: store data.
REQ-009 SHALL provide ex_out, input, 32 bits: ALU result.
REQ-010 SHALL provide bus_ack, input, 1 bit: memory access done.
REQ-011 SHALL provide bus_rd_data, input, 32 bits: read data, valid with bus_ack.
REQ-012 SHALL provide bus_req, output, 1 bit, registered: access request.
REQ-013 SHALL provide bus_rw, output, 1 bit, registered: 1 write, 0 read.
REQ-014 SHALL provide bus_addr, output, 32 bits, registered: word address, with {ex_addr[31:2], 2'b00}.
REQ-015 SHALL provide bus_be, output, 4 bits, registered: byte enables; bit n enables bits 8n+7:8n.
REQ-016 SHALL provide bus_wr_data, output, 32 bits, registered: lane-replicated store data.
REQ-017 SHALL provide out, output, 32 bits: MEM-stage result to the MEM/WB register.
REQ-018 SHALL provide miss_align, output, 1 bit: misaligned access detected.
REQ-019 SHALL provide busy, output, 1 bit: stall request; combinational and not dependent on stall.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-021 SHALL define a memory op as ex_en=1 with op 1-8.
REQ-022 SHALL define misalignment as LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-023 In IDLE, on an aligned memory op with flush=0, SHALL go to ACCESS, and register bus_req=1, bus_rw, bus_addr, bus_be and bus_wr_data.
REQ-024 In IDLE with a misaligned op and flush=0, SHALL set miss_align=1 and out=0, issue no request, and hold busy=0.
REQ-025 In IDLE with no memory op, SHALL set out=ex_out and miss_align=0.
REQ-026 SHALL set busy=1 in IDLE when REQ-023 accepts, and throughout ACCESS; busy SHALL be 0 otherwise.
REQ-027 SHALL set store byte enables: SB 0001<<addr[1:0] with data {4{byte}}; SH 0011 or 1100 by addr[1] with data {2{half}}; SW 1111.
REQ-028 SHALL hold bus_req and all bus outputs stable in ACCESS until the cycle bus_ack=1 is sampled, then clear bus_req at that edge.
REQ-029 On ack, SHALL capture the formatted load data into rd_buf (little-endian): LB/LBU byte addr[1:0], LH/LHU half addr[1], sign- or zero-extended; stores capture 0.
REQ-030 On ack SHALL go to DONE, unless a kill flag is set, in which case it goes to IDLE with rd_buf unchanged.
REQ-031 flush=1 in ACCESS SHALL set kill; the bus transaction SHALL still complete; kill SHALL clear on leaving ACCESS.
REQ-032 In DONE, SHALL set out=rd_buf, miss_align=0 and busy=0; SHALL stay in DONE while stall=1, and go to IDLE at the first edge with stall=0 or flush=1.
REQ-033 In DONE, SHALL NOT reissue for the still-present EX op.
REQ-034 bus_ack outside ACCESS SHALL be ignored.
REQ-035 Minimum latency: request visible 1 cycle after accept; result presented 1 cycle after ack; zero-wait load completes in 3 cycles.

Reset
REQ-036 reset=1 SHALL force IDLE, kill=0, bus_req=0, bus_rw=0, bus_addr=0, bus_be=0, bus_wr_data=0 and rd_buf=0; reset has priority over all inputs.
REQ-037 Reset mid-ACCESS SHALL abandon the transaction: bus_req=0 next cycle, no DONE.
REQ-038 After reset with ex_en=0, SHALL output out=0 (ex_out=0), miss_align=0, busy=0.

Verification
REQ-039 LB, addr 0x103, bus_rd_data 0x80FF_1234, ack after 2 wait cycles -> bus_addr 0x100, be 0000, busy 1 for 4 cycles, then out 0xFFFF_FF80.
REQ-040 SH, addr 0x202, data 0x0000_ABCD -> bus_rw 1, be 1100, bus_wr_data 0xABCD_ABCD, out 0 in DONE.
REQ-041 LW, addr 0x301 -> miss_align 1, out 0, busy 0, bus_req never asserted.
REQ-042 LHU accepted, flush during ACCESS, ack next cycle -> IDLE directly, busy 0, no DONE.
REQ-043 Load complete with stall held 3 cycles from DONE -> out stable for 4 cycles, single bus_req pulse train, no reissue.
REQ-044 Reset asserted in ACCESS -> bus_req 0 and state IDLE next cycle; later ack ignored.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues one bus transaction per aligned EX memory op,
// formats returned load data and stalls the pipeline while the access is outstanding.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_en,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wr_data,
  input  logic [31:0] ex_out,
  input  logic        bus_ack,
  input  logic [31:0] bus_rd_data,
  output logic        bus_req,
  output logic        bus_rw,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wr_data,
  output logic [31:0] out,
  output logic        miss_align,
  output logic        busy
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic        kill;
  logic [31:0] rd_buf;
  logic [3:0]  op_q;
  logic [1:0]  lo_q;

  logic        is_mem;
  logic        is_store;
  logic        misaligned;
  logic        accept;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  // Extracts and extends the addressed byte/half of a little-endian read word.
  function automatic logic [31:0] format_load(input logic [3:0]  op,
                                              input logic [1:0]  lo,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      OP_LW:   r = d;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    is_mem   = ex_en && (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_SW);
    is_store = (ex_mem_op == OP_SB) || (ex_mem_op == OP_SH) || (ex_mem_op == OP_SW);
    misaligned = is_mem &&
                 ((((ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH))
                   && ex_addr[0]) ||
                  (((ex_mem_op == OP_LW) || (ex_mem_op == OP_SW)) && (ex_addr[1:0] != 2'b00)));
    accept = (state == IDLE) && is_mem && !misaligned && !flush;
  end

  // Store lanes are replicated so the bus can pick any lane selected by the enables.
  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'd0;
    case (ex_mem_op)
      OP_SB: begin
        st_be   = 4'b0001 << ex_addr[1:0];
        st_data = {4{ex_wr_data[7:0]}};
      end
      OP_SH: begin
        st_be   = ex_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{ex_wr_data[15:0]}};
      end
      OP_SW: begin
        st_be   = 4'b1111;
        st_data = ex_wr_data;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = 32'd0;
      end
    endcase
  end

  // A flush during ACCESS cannot cancel the bus cycle, so it is remembered in kill
  // and the result is simply dropped when the ack arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      kill        <= 1'b0;
      bus_req     <= 1'b0;
      bus_rw      <= 1'b0;
      bus_addr    <= 32'd0;
      bus_be      <= 4'b0000;
      bus_wr_data <= 32'd0;
      rd_buf      <= 32'd0;
      op_q        <= 4'd0;
      lo_q        <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= ACCESS;
            bus_req     <= 1'b1;
            bus_rw      <= is_store;
            bus_addr    <= {ex_addr[31:2], 2'b00};
            bus_be      <= st_be;
            bus_wr_data <= st_data;
            op_q        <= ex_mem_op;
            lo_q        <= ex_addr[1:0];
          end
        end
        ACCESS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            kill    <= 1'b0;
            if (kill || flush) begin
              state <= IDLE;
            end else begin
              state  <= DONE;
              rd_buf <= format_load(op_q, lo_q, bus_rd_data);
            end
          end else if (flush) begin
            kill <= 1'b1;
          end
        end
        DONE: begin
          if (!stall || flush) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    out        = 32'd0;
    miss_align = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        busy = accept;
        if (!is_mem) begin
          out = ex_out;
        end else if (misaligned && !flush) begin
          miss_align = 1'b1;
        end
      end
      ACCESS:  busy = 1'b1;
      DONE:    out  = rd_buf;
      default: out  = 32'd0;
    endcase
  end

endmodule
